// File: rtl/dmem_access_unit.sv
// dmem_access_unit
//   Initiator side of the word-addressed data memory port between the MEM
//   stage and dmem. Turns lb/lbu/lh/lhu/lw/sb/sh/sw into word accesses,
//   extends sub-word load data, and performs a two-cycle read-modify-write
//   for sb/sh. Misaligned accesses and unused op codes are flagged without
//   touching memory.
// Ports
//   clk, reset               rising-edge clock, synchronous active-high reset
//   req_valid/req_ready      MEM-stage handshake; req_ready=0 stalls (RMW busy)
//   req_store, req_op        1=store; 000 b, 001 h, 010 w, 100 bu, 101 hu
//   req_addr, req_wdata      byte address, right-justified store data
//   resp_valid/resp_err      one-cycle completion pulse, error qualifier
//   resp_rdata               extended load data (0 for stores/errors)
//   mem_a/mem_wd/mem_we      dmem address, write word, write enable
//   mem_rd                   dmem combinational read data for mem_a
module dmem_access_unit #(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  output logic              mem_we,
  input  logic [31:0]       mem_rd
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic [1:0]  byte_lane;
  logic        half_hi;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] merged;
  logic        illegal, misaligned, err;

  // Big-endian mirrors the lane: 3-addr[1:0] is the bitwise inverse.
  assign byte_lane = BIG_ENDIAN ? ~req_addr[1:0] : req_addr[1:0];
  assign half_hi   = BIG_ENDIAN ? ~req_addr[1]   : req_addr[1];

  assign ld_byte = mem_rd[{byte_lane, 3'b000} +: 8];
  assign ld_half = mem_rd[{half_hi, 4'b0000} +: 16];

  assign illegal    = (req_op == 3'b011) || (req_op == 3'b110) || (req_op == 3'b111) ||
                      (req_store && req_op[2]);
  assign misaligned = ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                      ((req_op[1:0] == 2'b01) && req_addr[0]);
  assign err        = illegal || misaligned;

  always_comb begin
    ld_data = '0;
    case (req_op)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'b0, ld_half};
      3'b010:  ld_data = mem_rd;
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    merged = mem_rd;
    if (req_op[1:0] == 2'b00) merged[{byte_lane, 3'b000} +: 8] = req_wdata[7:0];
    else                      merged[{half_hi, 4'b0000} +: 16] = req_wdata[15:0];
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    word_d       = word_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    mem_a        = req_addr;
    mem_wd       = req_wdata;
    mem_we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req_store) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = ld_data;
          end else if (req_op[1:0] == 2'b10) begin
            mem_we       = 1'b1;
            resp_valid_d = 1'b1;
          end else begin
            addr_d  = req_addr;
            word_d  = merged;
            state_d = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        mem_a        = addr_q;
        mem_wd       = word_q;
        mem_we       = 1'b1;
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset suppresses the write combinationally so an in-flight RMW never lands.
    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      word_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      word_q       <= word_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule
